// File: rtl/add_serial_pkg.sv
// -----------------------------------------------------------------------------
// add_serial_pkg
// Shared definitions for the serial-add scheduler slice:
//   - default requester count and operand width
//   - scheduler state encoding (2-bit)
//   - majority-of-three helper used for the carry of the bit-serial adder
// -----------------------------------------------------------------------------
package add_serial_pkg;

   localparam int DEF_NREQ = 4;
   localparam int DEF_W    = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADD  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Carry of a full adder: set when at least two of the three inputs are set.
   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/add_serial_sched_if.sv
// -----------------------------------------------------------------------------
// add_serial_sched_if
// Bundle between the requesting control units (master) and the serial-add
// scheduler (slave).
//   req      requester -> scheduler  one request bit per requester
//   a_in     requester -> scheduler  operand A, requester k in [k*W +: W]
//   b_in     requester -> scheduler  operand B, same packing
//   gnt      scheduler -> requester  one-hot grant pulse
//   busy     scheduler -> requester  add in progress or completing
//   done     scheduler -> requester  one-cycle completion pulse
//   done_id  scheduler -> requester  id of the completed requester
//   result   scheduler -> requester  (A+B) mod 2^W, held until next done
//   cout     scheduler -> requester  carry out of the MSB, held with result
// -----------------------------------------------------------------------------
interface add_serial_sched_if #(
   parameter int NREQ = add_serial_pkg::DEF_NREQ,
   parameter int W    = add_serial_pkg::DEF_W
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] a_in;
   logic [NREQ*W-1:0] b_in;
   logic [NREQ-1:0]   gnt;
   logic              busy;
   logic              done;
   logic [IDW-1:0]    done_id;
   logic [W-1:0]      result;
   logic              cout;

   modport master (
      output req, a_in, b_in,
      input  gnt, busy, done, done_id, result, cout
   );

   modport slave (
      input  req, a_in, b_in,
      output gnt, busy, done, done_id, result, cout
   );

endinterface

// File: rtl/serial_add_core.sv
// -----------------------------------------------------------------------------
// serial_add_core
// Bit-serial adder datapath, LSB first, one bit per shift strobe.
//   clk, rst   clock and asynchronous active-high reset
//   load_i     capture operands, clear carry, count and partial sum
//   shift_i    add the current LSBs and shift everything right by one
//   a_i, b_i   operands captured on load_i
//   last_o     the bit being added now is the MSB (count == W-1)
//   sum_o      partial sum including the bit being added this cycle
//   cout_o     carry produced by the bit being added this cycle
// sum_o/cout_o include the current bit so the scheduler can register the
// finished result on the same edge that retires the MSB.
// -----------------------------------------------------------------------------
module serial_add_core
   import add_serial_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         last_o,
   output logic [W-1:0] sum_o,
   output logic         cout_o
);
   localparam int CW = $clog2(W);

   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  sum_q;
   logic          carry_q;
   logic [CW-1:0] count_q;

   logic          bit_s;
   logic          carry_s;

   assign bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
   assign carry_s = maj3(a_q[0], b_q[0], carry_q);

   // Operand capture and one-bit-per-cycle shift/add.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
      end else if (load_i) begin
         a_q     <= a_i;
         b_q     <= b_i;
         sum_q   <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
      end else if (shift_i) begin
         a_q     <= {1'b0, a_q[W-1:1]};
         b_q     <= {1'b0, b_q[W-1:1]};
         sum_q   <= {bit_s, sum_q[W-1:1]};
         carry_q <= carry_s;
         count_q <= count_q + CW'(1);
      end else begin
         a_q     <= a_q;
         b_q     <= b_q;
         sum_q   <= sum_q;
         carry_q <= carry_q;
         count_q <= count_q;
      end
   end

   assign last_o = (count_q == CW'(W - 1));
   assign sum_o  = {bit_s, sum_q[W-1:1]};
   assign cout_o = carry_s;

endmodule

// File: rtl/add_serial_sched.sv
// -----------------------------------------------------------------------------
// add_serial_sched
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
//   clk   clock, all state updates on posedge
//   rst   asynchronous active-high reset
//   bus   add_serial_sched_if.slave: req/a_in/b_in in, gnt/busy/done/done_id/
//         result/cout out (all outputs registered)
// Flow: IDLE picks the first requester at or after ptr (wrapping), latches its
// operands and pulses gnt; ADD runs W serial bit steps; DONE pulses done for
// one cycle and moves ptr past the winner.
// -----------------------------------------------------------------------------
module add_serial_sched
   import add_serial_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int W    = DEF_W
) (
   input  logic              clk,
   input  logic              rst,
   add_serial_sched_if.slave bus
);
   localparam int IDW = $clog2(NREQ);

   // Returns {found, id}: first set request searching upward from p, wrapping.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IDW-1:0]  p);
      logic           found;
      logic [IDW-1:0] id;
      logic [IDW-1:0] idx;
      found = 1'b0;
      id    = p;
      for (int i = 0; i < NREQ; i++) begin
         idx = IDW'((int'(p) + i) % NREQ);
         if (!found && r[idx]) begin
            found = 1'b1;
            id    = idx;
         end
      end
      return {found, id};
   endfunction

   state_t          state_q;
   logic [IDW-1:0]  ptr_q;
   logic [IDW-1:0]  cur_id_q;
   logic [NREQ-1:0] gnt_q;
   logic            busy_q;
   logic            done_q;
   logic [IDW-1:0]  done_id_q;
   logic [W-1:0]    result_q;
   logic            cout_q;

   logic [W-1:0]    a_arr_s [NREQ];
   logic [W-1:0]    b_arr_s [NREQ];
   logic            pick_found_s;
   logic [IDW-1:0]  pick_id_s;
   logic [IDW-1:0]  ptr_next_s;
   logic            load_s;
   logic            shift_s;
   logic            core_last_s;
   logic [W-1:0]    core_sum_s;
   logic            core_cout_s;

   // Unpack the flat operand buses into per-requester slices.
   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         a_arr_s[k] = bus.a_in[k*W +: W];
         b_arr_s[k] = bus.b_in[k*W +: W];
      end
   end

   assign {pick_found_s, pick_id_s} = rr_pick(bus.req, ptr_q);
   assign ptr_next_s = (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + IDW'(1);
   assign load_s     = (state_q == ST_IDLE) && pick_found_s;
   assign shift_s    = (state_q == ST_ADD);

   serial_add_core #(.W(W)) u_core (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_s),
      .shift_i (shift_s),
      .a_i     (a_arr_s[pick_id_s]),
      .b_i     (b_arr_s[pick_id_s]),
      .last_o  (core_last_s),
      .sum_o   (core_sum_s),
      .cout_o  (core_cout_s)
   );

   // Scheduler FSM with registered grant, busy and completion outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         cur_id_q  <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         result_q  <= '0;
         cout_q    <= 1'b0;
      end else begin
         gnt_q  <= '0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pick_found_s) begin
                  gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << pick_id_s;
                  cur_id_q <= pick_id_s;
                  busy_q   <= 1'b1;
                  state_q  <= ST_ADD;
               end else begin
                  busy_q   <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            ST_ADD: begin
               // The MSB retires on this edge; capture the finished sum now so
               // done and result appear together in the DONE cycle.
               if (core_last_s) begin
                  done_q    <= 1'b1;
                  result_q  <= core_sum_s;
                  cout_q    <= core_cout_s;
                  done_id_q <= cur_id_q;
                  state_q   <= ST_DONE;
               end else begin
                  state_q   <= ST_ADD;
               end
            end
            ST_DONE: begin
               ptr_q   <= ptr_next_s;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
   assign bus.result  = result_q;
   assign bus.cout    = cout_q;

endmodule

// File: tb/tb_add_serial_sched.sv
// -----------------------------------------------------------------------------
// tb_add_serial_sched
// Transaction-level reference: a grant starts W+1 busy cycles, the last of
// which carries done with (A+B) computed arithmetically. Directed scenarios
// pin the reference with literal values, then a random phase runs.
// -----------------------------------------------------------------------------
module tb_add_serial_sched;
   localparam int NREQ = 4;
   localparam int W    = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   add_serial_sched_if #(.NREQ(NREQ), .W(W)) bus ();
   add_serial_sched #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int gnt_ids[$];
   int done_cycs[$];

   // Reference model state
   int              m_busy = 0;
   int              m_ptr  = 0;
   int              m_cur  = 0;
   int              m_sum  = 0;
   logic [NREQ-1:0] e_gnt;
   logic            e_busy;
   logic            e_done;
   int              e_id;
   logic [W-1:0]    e_res;
   logic            e_cout;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model step plus compare, 1 time unit after each rising edge.
   always begin
      bit found;
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         m_busy = 0; m_ptr = 0; m_cur = 0; m_sum = 0;
         e_gnt = '0; e_busy = 1'b0; e_done = 1'b0; e_id = 0; e_res = '0; e_cout = 1'b0;
      end else begin
         e_gnt  = '0;
         e_done = 1'b0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) m_ptr = (m_cur + 1) % NREQ;
         end else if (|bus.req) begin
            found = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
               int k;
               k = (m_ptr + i) % NREQ;
               if (!found && bus.req[k]) begin
                  found = 1'b1;
                  m_cur = k;
               end
            end
            m_sum = int'(bus.a_in[m_cur*W +: W]) + int'(bus.b_in[m_cur*W +: W]);
            e_gnt[m_cur] = 1'b1;
            m_busy = W + 1;
         end
         e_busy = (m_busy > 0);
         if (m_busy == 1) begin
            e_done = 1'b1;
            e_res  = W'(m_sum);
            e_cout = m_sum[W];
            e_id   = m_cur;
         end
      end
      chk("gnt", 32'(bus.gnt), 32'(e_gnt));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("done_id", 32'(bus.done_id), e_id);
      chk("result", 32'(bus.result), 32'(e_res));
      chk("cout", 32'(bus.cout), 32'(e_cout));
      for (int k = 0; k < NREQ; k++) if (bus.gnt[k]) gnt_ids.push_back(k);
      if (bus.done) done_cycs.push_back(cyc);
   end

   task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.a_in[k*W +: W] = a;
      bus.b_in[k*W +: W] = b;
   endtask

   task automatic wait_gnt(input int budget, output int c, output logic [NREQ-1:0] g);
      c = -1;
      g = '0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.gnt != '0) begin
            c = cyc;
            g = bus.gnt;
            break;
         end
      end
      if (c < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL gnt_timeout: no grant within %0d cycles (cycle %0d)", budget, cyc);
      end
   endtask

   task automatic wait_done(input int budget, output int c);
      c = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.done) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", budget, cyc);
      end
   endtask

   function automatic logic [W-1:0] rnd_op();
      case ($urandom % 4)
         0:       return '0;
         1:       return '1;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1);
   end

   initial begin
      int c, c2, g_cyc, n0;
      logic [NREQ-1:0] g;
      int exp3[5] = '{0, 1, 2, 3, 0};

      rst = 1'b1;
      bus.req  = '0;
      bus.a_in = '0;
      bus.b_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_cout", 32'(bus.cout), 32'd0);
      chk("rst_done_id", 32'(bus.done_id), 32'd0);
      rst = 1'b0;

      // 1: basic add and latency
      set_ops(0, 8'h5A, 8'hA5);
      bus.req = 4'b0001;
      wait_gnt(20, c, g);
      chk("t1_gnt", 32'(g), 32'h1);
      bus.req = '0;
      g_cyc = c;
      @(negedge clk);
      chk("t1_gnt_pulse", 32'(bus.gnt), 32'd0);
      wait_done(40, c);
      chk("t1_latency", c - g_cyc, W);
      chk("t1_result", 32'(bus.result), 32'hFF);
      chk("t1_cout", 32'(bus.cout), 32'd0);
      chk("t1_done_id", 32'(bus.done_id), 32'd0);

      // 2: overflow wraps, carry on cout
      set_ops(2, 8'hFF, 8'h01);
      bus.req = 4'b0100;
      wait_gnt(20, c, g);
      chk("t2_gnt", 32'(g), 32'h4);
      bus.req = '0;
      wait_done(40, c);
      chk("t2_result", 32'(bus.result), 32'h00);
      chk("t2_cout", 32'(bus.cout), 32'd1);
      chk("t2_done_id", 32'(bus.done_id), 32'd2);

      // 3: all requesting from reset -> cyclic order, W+2 spacing
      rst = 1'b1;
      @(negedge clk);
      gnt_ids.delete();
      done_cycs.delete();
      for (int k = 0; k < NREQ; k++) set_ops(k, rnd_op(), rnd_op());
      bus.req = 4'b1111;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 5; n++) wait_done(60, c);
      bus.req = '0;
      if (gnt_ids.size() < 5 || done_cycs.size() < 5) begin
         n_checks++;
         n_fail++;
         $display("FAIL t3_count: got %0d grants %0d dones, required 5 each", gnt_ids.size(), done_cycs.size());
      end else begin
         for (int i = 0; i < 5; i++) chk("t3_order", gnt_ids[i], exp3[i]);
         for (int i = 0; i < 4; i++) chk("t3_spacing", done_cycs[i+1] - done_cycs[i], W + 2);
      end

      // 4: ptr=1 after serving 0 -> 3 before 0
      set_ops(0, 8'h11, 8'h22);
      set_ops(3, 8'h40, 8'h0C);
      bus.req = 4'b1001;
      wait_gnt(20, c, g);
      chk("t4_first", 32'(g), 32'h8);
      bus.req[3] = 1'b0;
      wait_done(40, c);
      chk("t4_result3", 32'(bus.result), 32'h4C);
      wait_gnt(20, c, g);
      chk("t4_second", 32'(g), 32'h1);
      bus.req[0] = 1'b0;
      wait_done(40, c);
      chk("t4_result0", 32'(bus.result), 32'h33);

      // 5: reset during ADD at count=4
      set_ops(2, 8'h70, 8'h07);
      bus.req = 4'b0100;
      wait_gnt(20, c, g);
      chk("t5_gnt", 32'(g), 32'h4);
      bus.req = '0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t5_rst_busy", 32'(bus.busy), 32'd0);
      chk("t5_rst_done", 32'(bus.done), 32'd0);
      chk("t5_rst_result", 32'(bus.result), 32'd0);
      chk("t5_rst_cout", 32'(bus.cout), 32'd0);
      chk("t5_rst_done_id", 32'(bus.done_id), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n0 = done_cycs.size();
      repeat (W + 4) @(negedge clk);
      chk("t5_no_done", done_cycs.size() - n0, 0);
      set_ops(1, 8'h03, 8'h04);
      set_ops(2, 8'h05, 8'h06);
      bus.req = 4'b0110;
      wait_gnt(20, c, g);
      chk("t5_from_ptr0", 32'(g), 32'h2);
      bus.req = '0;
      wait_done(40, c);
      chk("t5_result", 32'(bus.result), 32'h07);

      // 6: operands/req changed during ADD; req rising during DONE
      set_ops(3, 8'h12, 8'h34);
      bus.req = 4'b1000;
      wait_gnt(20, c, g);
      chk("t6_gnt", 32'(g), 32'h8);
      bus.req = '0;
      set_ops(3, 8'hFF, 8'hFF);
      wait_done(40, c);
      chk("t6_result", 32'(bus.result), 32'h46);
      chk("t6_cout", 32'(bus.cout), 32'd0);
      set_ops(0, 8'h80, 8'h80);
      bus.req = 4'b0001;
      wait_gnt(20, c2, g);
      chk("t6_late_gnt", 32'(g), 32'h1);
      chk("t6_late_delay", c2 - c, 2);
      bus.req = '0;
      set_ops(0, 8'h01, 8'h01);
      wait_done(40, c);
      chk("t6_late_result", 32'(bus.result), 32'h00);
      chk("t6_late_cout", 32'(bus.cout), 32'd1);
      chk("t6_late_id", 32'(bus.done_id), 32'd0);

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         for (int k = 0; k < NREQ; k++) begin
            if (bus.gnt[k]) begin
               bus.req[k] = 1'b0;
               set_ops(k, rnd_op(), rnd_op());
            end else if (!bus.req[k]) begin
               if ($urandom % 8 == 0) bus.req[k] = 1'b1;
               set_ops(k, rnd_op(), rnd_op());
            end else if ($urandom % 64 == 0) begin
               bus.req[k] = 1'b0;
            end
         end
      end
      bus.req = '0;
      repeat (W + 4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
